// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: table geometry helpers,
// counter initial values and the per-entry update classification.
package branch_predictor_pkg;

  function automatic int unsigned idx_w(input int unsigned entries);
    return $clog2(entries);
  endfunction

  function automatic int unsigned tag_w(input int unsigned xlen, input int unsigned entries);
    return xlen - $clog2(entries) - 2;
  endfunction

  function automatic int unsigned ctr_weak_taken(input int unsigned ctr_w);
    return 1 << (ctr_w - 1);
  endfunction

  function automatic int unsigned ctr_weak_not_taken(input int unsigned ctr_w);
    return (1 << (ctr_w - 1)) - 1;
  endfunction

  // Generic entry layout at the default geometry; the top re-derives the
  // same field order at its own parameterisation.
  localparam int unsigned BP_XLEN    = 32;
  localparam int unsigned BP_ENTRIES = 64;
  localparam int unsigned BP_CTR_W   = 2;

  typedef struct packed {
    logic                                  valid;
    logic [BP_XLEN-$clog2(BP_ENTRIES)-3:0] tag;
    logic [BP_XLEN-1:0]                    target;
    logic [BP_CTR_W-1:0]                   ctr;
  } bp_entry_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down counter step: returns the next value for one event.
module sat_counter #(
  parameter int unsigned CTR_W = 2
) (
  input  logic [CTR_W-1:0] count_i,
  input  logic             inc_i,
  output logic [CTR_W-1:0] next_c_o
);

  always_comb begin
    next_c_o = count_i;
    if (inc_i) begin
      if (!(&count_i)) next_c_o = count_i + CTR_W'(1);
    end else begin
      if (|count_i) next_c_o = count_i - CTR_W'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters,
// combinational lookup and single-port registered update plus statistics.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned CTR_W   = 2,
  parameter int unsigned STAT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [XLEN-1:0]   lookup_pc_i,
  output logic              pred_hit_o,
  output logic              pred_taken_o,
  output logic [XLEN-1:0]   pred_target_o,
  input  logic              upd_valid_i,
  input  logic [XLEN-1:0]   upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [XLEN-1:0]   upd_target_i,
  input  logic              upd_pred_taken_i,
  output logic [STAT_W-1:0] stat_branches_o,
  output logic [STAT_W-1:0] stat_mispred_o
);

  localparam int unsigned IDX_W = idx_w(ENTRIES);
  localparam int unsigned TAG_W = tag_w(XLEN, ENTRIES);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
    logic [CTR_W-1:0] ctr;
  } entry_t;

  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(ctr_weak_taken(CTR_W));
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'(ctr_weak_not_taken(CTR_W));
  localparam entry_t ENTRY_RST = '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};

  entry_t              tbl_q [ENTRIES];
  logic [STAT_W-1:0]   stat_branches_q, stat_branches_d;
  logic [STAT_W-1:0]   stat_mispred_q, stat_mispred_d;

  logic [IDX_W-1:0]    lk_idx_c;
  logic [IDX_W-1:0]    upd_idx_c;
  logic [TAG_W-1:0]    upd_tag_c;
  entry_t              upd_old_c, upd_new_c;
  logic                upd_hit_c, upd_we_c, mispred_c;
  logic [CTR_W-1:0]    ctr_next_c;
  logic                pc_lsb_unused;

  assign pc_lsb_unused = ^upd_pc_i[1:0];

  // Lookup reads the registered table only, so same-cycle updates are not visible.
  always_comb begin
    lk_idx_c      = lookup_pc_i[IDX_W+1:2];
    pred_hit_o    = tbl_q[lk_idx_c].valid && (tbl_q[lk_idx_c].tag == lookup_pc_i[XLEN-1:IDX_W+2]);
    pred_taken_o  = pred_hit_o && tbl_q[lk_idx_c].ctr[CTR_W-1];
    pred_target_o = pred_taken_o ? tbl_q[lk_idx_c].target : lookup_pc_i + XLEN'(4);
  end

  sat_counter #(.CTR_W(CTR_W)) u_sat_counter (
    .count_i  (upd_old_c.ctr),
    .inc_i    (upd_taken_i),
    .next_c_o (ctr_next_c)
  );

  always_comb begin
    upd_idx_c = upd_pc_i[IDX_W+1:2];
    upd_tag_c = upd_pc_i[XLEN-1:IDX_W+2];
    upd_old_c = tbl_q[upd_idx_c];
    upd_hit_c = upd_old_c.valid && (upd_old_c.tag == upd_tag_c);
    upd_we_c  = 1'b0;
    upd_new_c = upd_old_c;
    mispred_c = (upd_pred_taken_i != upd_taken_i) ||
                (upd_taken_i && upd_pred_taken_i &&
                 (!upd_hit_c || (upd_old_c.target != upd_target_i)));
    if (upd_valid_i) begin
      if (upd_hit_c) begin
        upd_we_c      = 1'b1;
        upd_new_c.ctr = ctr_next_c;
        if (upd_taken_i) upd_new_c.target = upd_target_i;
      end else if (upd_taken_i) begin
        upd_we_c  = 1'b1;
        upd_new_c = '{valid: 1'b1, tag: upd_tag_c, target: upd_target_i, ctr: CTR_WT};
      end
    end
  end

  always_comb begin
    stat_branches_d = stat_branches_q;
    stat_mispred_d  = stat_mispred_q;
    if (upd_valid_i) begin
      if (!(&stat_branches_q)) stat_branches_d = stat_branches_q + STAT_W'(1);
      if (mispred_c && !(&stat_mispred_q)) stat_mispred_d = stat_mispred_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < ENTRIES; i++) tbl_q[i] <= ENTRY_RST;
      stat_branches_q <= '0;
      stat_mispred_q  <= '0;
    end else begin
      if (upd_we_c) tbl_q[upd_idx_c] <= upd_new_c;
      stat_branches_q <= stat_branches_d;
      stat_mispred_q  <= stat_mispred_d;
    end
  end

  assign stat_branches_o = stat_branches_q;
  assign stat_mispred_o  = stat_mispred_q;

endmodule
